// File: rtl/scaler_pkg.sv
// scaler_pkg: shared types and limits for the scaler line reader.
// The user field exists only when SCALER_LINE_READER_SOF_EN is defined.
package scaler_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int PIX_W      = 12;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             last;
`ifdef SCALER_LINE_READER_SOF_EN
    logic             user;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/scaler_reader_fifo.sv
// scaler_reader_fifo: small synchronous FIFO with occupancy count.
// DEPTH must be a power of 2 so the pointers wrap on their own.
module scaler_reader_fifo
  import scaler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  fifo_entry_t              din_i,
  input  logic                     pop_i,
  output fifo_entry_t              dout_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  // storage, pointers and occupancy; push+pop leaves count unchanged
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // the read credit scheme must keep a full FIFO from ever being pushed
  assert property (@(posedge clk_i) disable iff (!resetn_i)
    !(push_i && !pop_i && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/scaler_line_reader.sv
// scaler_line_reader: reads one line from a fixed-latency line buffer
// and streams it out via a credit-limited FIFO. Option: SCALER_LINE_READER_SOF_EN.
module scaler_line_reader
  import scaler_pkg::*;
#(
  parameter int C_DATA_WIDTH = PIX_W,
  parameter int C_ADDR_WIDTH = 11,
  parameter int C_RD_LATENCY = 1,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [C_ADDR_WIDTH-1:0] line_width,
`ifdef SCALER_LINE_READER_SOF_EN
  input  logic                    sof_in,
  output logic                    m_user,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  input  logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    m_valid,
  output logic [C_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  input  logic                    m_ready
);

  localparam int AW = C_ADDR_WIDTH;
  localparam int L  = C_RD_LATENCY;
  localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] width_q;
  logic [L-1:0]  pv_q;
  logic [L-1:0]  pl_q;
`ifdef SCALER_LINE_READER_SOF_EN
  logic          sof_q;
  logic [L-1:0]  pu_q;
`endif

  logic [AW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  fifo_entry_t   push_e;
  fifo_entry_t   head_e;
  logic          credit_ok;
  logic          rd_fire;
  logic          last_rd;
  logic          pop;

  // reads issued but not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++)
      inflight = inflight + AW'(pv_q[i]);
  end

  assign credit_ok = (AW'(fifo_cnt) + inflight) < AW'(C_FIFO_DEPTH);
  assign rd_fire   = (state_q == READ) && credit_ok;
  assign last_rd   = (addr_q == width_q - AW'(1));
  assign pop       = !fifo_empty && m_ready;

  // line sequencing: accept start, walk addresses, wait for last beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      width_q <= '0;
`ifdef SCALER_LINE_READER_SOF_EN
      sof_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && line_width != '0) begin
            width_q <= line_width;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= READ;
`ifdef SCALER_LINE_READER_SOF_EN
            sof_q   <= sof_in;
`endif
          end else if (start) begin
            done_q <= 1'b1;
          end
        end
        READ: begin
          if (rd_fire) begin
            if (last_rd) state_q <= DRAIN;
            else         addr_q  <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
          if (pop && head_e.last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // valid/last/user shift pipe matching the buffer read latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pv_q <= '0;
      pl_q <= '0;
`ifdef SCALER_LINE_READER_SOF_EN
      pu_q <= '0;
`endif
    end else begin
      pv_q[0] <= rd_fire;
      pl_q[0] <= rd_fire && last_rd;
`ifdef SCALER_LINE_READER_SOF_EN
      pu_q[0] <= rd_fire && sof_q && (addr_q == '0);
`endif
      for (int i = 1; i < L; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
`ifdef SCALER_LINE_READER_SOF_EN
        pu_q[i] <= pu_q[i-1];
`endif
      end
    end
  end

  // pair returning buffer data with the flags of its read
  always_comb begin
    push_e      = '0;
    push_e.data = rd_data;
    push_e.last = pl_q[L-1];
`ifdef SCALER_LINE_READER_SOF_EN
    push_e.user = pu_q[L-1];
`endif
  end

  scaler_reader_fifo #(
    .DEPTH(C_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .resetn_i(resetn),
    .push_i  (pv_q[L-1]),
    .din_i   (push_e),
    .pop_i   (pop),
    .dout_o  (head_e),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_fire;
  assign rd_addr = addr_q;
  assign m_valid = !fifo_empty;
  assign m_data  = head_e.data;
  assign m_last  = !fifo_empty && head_e.last;
`ifdef SCALER_LINE_READER_SOF_EN
  assign m_user  = !fifo_empty && head_e.user;
`endif

  // latency and depth must leave room for a full-rate credit loop
  assert property (@(posedge clk) disable iff (!resetn)
    C_RD_LATENCY >= RD_LAT_MIN && C_RD_LATENCY <= RD_LAT_MAX &&
    C_FIFO_DEPTH >= C_RD_LATENCY + 2);

endmodule

// File: tb/tb_scaler_line_reader.sv
// tb_scaler_line_reader: directed bench, read latency 1 and 2 side by side.
// Covers m_user when SCALER_LINE_READER_SOF_EN is defined.
module tb_scaler_line_reader;

  localparam int NB = 128;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        m_ready;
  logic [10:0] line_width;
`ifdef SCALER_LINE_READER_SOF_EN
  logic        sof_in;
`endif

  logic        busy    [2];
  logic        done    [2];
  logic        rd_en   [2];
  logic [10:0] rd_addr [2];
  logic [11:0] rd_data [2];
  logic        m_valid [2];
  logic [11:0] m_data  [2];
  logic        m_last  [2];
  logic        m_user  [2];
  logic [11:0] mem1, mem2a, mem2b;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;
  int ts;

  logic [11:0] bd   [2][NB];
  logic        bl   [2][NB];
  logic        bu   [2][NB];
  int          bcyc [2][NB];
  int nb[2]       = '{0, 0};
  int rd_cnt[2]   = '{0, 0};
  int ost[2]      = '{0, 0};
  int max_out[2]  = '{0, 0};
  int done_cnt[2] = '{0, 0};
  int done_cyc[2] = '{0, 0};
  int stab_err[2] = '{0, 0};
  logic        pstall[2] = '{1'b0, 1'b0};
  logic [11:0] pdata[2];
  int b0[2], d0[2], r0[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scaler_line_reader #(.C_RD_LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn), .start(start), .line_width(line_width),
`ifdef SCALER_LINE_READER_SOF_EN
    .sof_in(sof_in), .m_user(m_user[0]),
`endif
    .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .m_valid(m_valid[0]), .m_data(m_data[0]), .m_last(m_last[0]),
    .m_ready(m_ready)
  );

  scaler_line_reader #(.C_RD_LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn), .start(start), .line_width(line_width),
`ifdef SCALER_LINE_READER_SOF_EN
    .sof_in(sof_in), .m_user(m_user[1]),
`endif
    .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .m_valid(m_valid[1]), .m_data(m_data[1]), .m_last(m_last[1]),
    .m_ready(m_ready)
  );

`ifndef SCALER_LINE_READER_SOF_EN
  assign m_user[0] = 1'b0;
  assign m_user[1] = 1'b0;
`endif

  function automatic logic [11:0] pix(input int a);
    return 12'h300 + a[11:0];
  endfunction

  // line buffer models: latency 1 and latency 2
  always @(posedge clk) begin
    mem1  <= rd_en[0] ? pix(int'(rd_addr[0])) : 12'hBAD;
    mem2a <= rd_en[1] ? pix(int'(rd_addr[1])) : 12'hBAD;
    mem2b <= mem2a;
  end
  assign rd_data[0] = mem1;
  assign rd_data[1] = mem2b;

  // record beats, reads, done pulses and stall stability
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        ost[k]    <= 0;
        pstall[k] <= 1'b0;
      end else begin
        ost[k] <= ost[k] + (rd_en[k] ? 1 : 0)
                  - ((m_valid[k] && m_ready) ? 1 : 0);
        if (ost[k] > max_out[k]) max_out[k] <= ost[k];
        if (rd_en[k]) rd_cnt[k] <= rd_cnt[k] + 1;
        if (m_valid[k] && m_ready) begin
          if (nb[k] < NB) begin
            bd[k][nb[k]]   <= m_data[k];
            bl[k][nb[k]]   <= m_last[k];
            bu[k][nb[k]]   <= m_user[k];
            bcyc[k][nb[k]] <= cyc;
          end
          nb[k] <= nb[k] + 1;
        end
        if (done[k]) begin
          done_cnt[k] <= done_cnt[k] + 1;
          done_cyc[k] <= cyc;
        end
        if (pstall[k] && m_valid[k] && m_data[k] != pdata[k])
          stab_err[k] <= stab_err[k] + 1;
        pstall[k] <= m_valid[k] && !m_ready;
        pdata[k]  <= m_data[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_line(input int w);
    for (int k = 0; k < 2; k++) begin
      b0[k] = nb[k];
      d0[k] = done_cnt[k];
      r0[k] = rd_cnt[k];
    end
    @(posedge clk);
    #1;
    ts         = cyc;
    start      = 1'b1;
    line_width = w[10:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int mode, input int budget);
    int i;
    i = 0;
    while (!(done_cnt[0] > d0[0] && done_cnt[1] > d0[1]) && i < budget) begin
      @(posedge clk);
      #1;
      m_ready = (mode == 1) ? ((i % 2) == 0) : 1'b1;
      i++;
    end
    chk({nm, ".in_time"}, 32'(i < budget), 1);
    m_ready = 1'b1;
  endtask

  task automatic check_line(input string nm, input int w, input bit lat);
    int f;
    for (int k = 0; k < 2; k++) begin
      f = b0[k];
      chk($sformatf("%s.beats[%0d]", nm, k), nb[k] - f, w);
      for (int i = 0; i < w; i++) begin
        chk($sformatf("%s.data[%0d][%0d]", nm, k, i), bd[k][f+i], pix(i));
        chk($sformatf("%s.last[%0d][%0d]", nm, k, i), bl[k][f+i],
            32'(i == w - 1));
      end
      chk($sformatf("%s.dones[%0d]", nm, k), done_cnt[k] - d0[k], 1);
      chk($sformatf("%s.done_cyc[%0d]", nm, k), done_cyc[k],
          bcyc[k][f+w-1] + 1);
      chk($sformatf("%s.busy[%0d]", nm, k), busy[k], 0);
      if (lat) begin
        chk($sformatf("%s.first[%0d]", nm, k), bcyc[k][f] - ts, 3 + k);
        chk($sformatf("%s.burst[%0d]", nm, k),
            bcyc[k][f+w-1] - bcyc[k][f], w - 1);
      end
    end
  endtask

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.busy[%0d]", nm, k), busy[k], 0);
      chk($sformatf("%s.done[%0d]", nm, k), done[k], 0);
      chk($sformatf("%s.rd_en[%0d]", nm, k), rd_en[k], 0);
      chk($sformatf("%s.rd_addr[%0d]", nm, k), rd_addr[k], 0);
      chk($sformatf("%s.m_valid[%0d]", nm, k), m_valid[k], 0);
      chk($sformatf("%s.m_last[%0d]", nm, k), m_last[k], 0);
      chk($sformatf("%s.m_data[%0d]", nm, k), m_data[k], 0);
    end
  endtask

  initial begin
    int i;
    int ds[2];
    int ns[2];
    resetn     = 1'b0;
    start      = 1'b0;
    line_width = '0;
    m_ready    = 1'b1;
`ifdef SCALER_LINE_READER_SOF_EN
    sof_in     = 1'b0;
`endif
    idle(3);
    chk_reset("por");
    resetn = 1'b1;
    idle(2);

    // full rate, 8 pixels
    begin_line(8);
    wait_done("full", 0, 100);
    idle(4);
    check_line("full", 8, 1);

    // alternating ready, 16 pixels
    begin_line(16);
    wait_done("bp", 1, 200);
    idle(4);
    check_line("bp", 16, 0);

    // stall 20 cycles then release, 10 pixels
    m_ready = 1'b0;
    begin_line(10);
    idle(20);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall.reads[%0d]", k), rd_cnt[k] - r0[k], 4);
      chk($sformatf("stall.valid[%0d]", k), m_valid[k], 1);
      chk($sformatf("stall.hold[%0d]", k), m_data[k], pix(0));
      chk($sformatf("stall.nobeat[%0d]", k), nb[k] - b0[k], 0);
    end
    wait_done("stall", 0, 200);
    idle(4);
    check_line("stall", 10, 0);

    // zero width: done only
    begin_line(0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("zero.done[%0d]", k), done[k], 1);
      chk($sformatf("zero.busy[%0d]", k), busy[k], 0);
    end
    idle(1);
    for (int k = 0; k < 2; k++)
      chk($sformatf("zero.pulse[%0d]", k), done[k], 0);
    idle(5);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("zero.reads[%0d]", k), rd_cnt[k] - r0[k], 0);
      chk($sformatf("zero.beats[%0d]", k), nb[k] - b0[k], 0);
      chk($sformatf("zero.dones[%0d]", k), done_cnt[k] - d0[k], 1);
    end

    // start while busy is ignored
    begin_line(5);
    start      = 1'b1;
    line_width = 11'd9;
    idle(1);
    start = 1'b0;
    wait_done("busy", 0, 100);
    idle(8);
    check_line("busy", 5, 1);

    // reset after 6 beats of a 12-pixel line
    begin_line(12);
    i = 0;
    while (nb[0] - b0[0] < 6 && i < 100) begin
      idle(1);
      i++;
    end
    chk("rst.reach", 32'(i < 100), 1);
    resetn = 1'b0;
    #1;
    chk_reset("rst.mid");
    for (int k = 0; k < 2; k++) begin
      ds[k] = done_cnt[k];
      ns[k] = nb[k];
    end
    idle(3);
    resetn = 1'b1;
    idle(4);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst.nodone[%0d]", k), done_cnt[k] - ds[k], 0);
      chk($sformatf("rst.nobeat[%0d]", k), nb[k] - ns[k], 0);
    end
    begin_line(3);
    wait_done("rst.after", 0, 100);
    idle(4);
    check_line("rst.after", 3, 1);

`ifdef SCALER_LINE_READER_SOF_EN
    // start-of-frame marker on first beat of a flagged line only
    sof_in = 1'b1;
    begin_line(3);
    sof_in = 1'b0;
    wait_done("sof1", 0, 100);
    idle(4);
    check_line("sof1", 3, 0);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("sof1.user[%0d][%0d]", k, j), bu[k][b0[k]+j],
            32'(j == 0));
    begin_line(3);
    wait_done("sof0", 0, 100);
    idle(4);
    check_line("sof0", 3, 0);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("sof0.user[%0d][%0d]", k, j), bu[k][b0[k]+j], 0);
`endif

    for (int k = 0; k < 2; k++) begin
      chk($sformatf("max_outstanding[%0d]", k), max_out[k], 4);
      chk($sformatf("stall_stable[%0d]", k), stab_err[k], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scaler_line_reader.md
Name: scaler_line_reader

Overview:
- Read-side counterpart to the scaler's stream-relay path.
- Fetches one line of pixels from a fixed-latency synchronous line buffer (BRAM read port).
- Presents the pixels as a valid/ready stream with an end-of-line marker.
- Absorbs downstream backpressure with a credit-limited output FIFO, so BRAM reads already in flight are never lost.

Parameters:
- C_DATA_WIDTH, 12, pixel width in bits.
- C_ADDR_WIDTH, 11, line-buffer address width; max line width 2^C_ADDR_WIDTH-1.
- C_RD_LATENCY, 1, BRAM read latency in cycles (legal 1..3).
- C_FIFO_DEPTH, 4, output FIFO entries; must be >= C_RD_LATENCY+2 and a power of 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begin reading a line; ignored while busy.
- line_width  in  C_ADDR_WIDTH  pixel count, sampled on an accepted start.
- busy  out  1  high from the accepted start until the last beat is accepted.
- done  out  1  one-cycle pulse on acceptance of the last beat.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  C_ADDR_WIDTH  BRAM read address.
- rd_data  in  C_DATA_WIDTH  BRAM data, valid C_RD_LATENCY cycles after rd_en.
- m_valid  out  1  stream valid.
- m_data  out  C_DATA_WIDTH  stream pixel.
- m_last  out  1  high on the final pixel of the line.
- m_ready  in  1  stream ready.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0. FIFO empty, in-flight pipe cleared, state IDLE.
- Reset asserted mid-line aborts the line. In-flight read data is discarded; no done pulse is issued.

State machine:
- IDLE: start with line_width!=0 -> latch width, rd_addr=0, go to READ, busy=1.
- IDLE: start with line_width==0 -> done pulses the next cycle; busy stays 0; no reads, no beats.
- READ: rd_en=1 whenever fifo_count + inflight < C_FIFO_DEPTH. rd_addr increments after each issued read. After issuing read width-1, go to DRAIN.
- DRAIN: no reads. When the beat with m_last is handshaked (m_valid & m_ready), pulse done, clear busy, go to IDLE.
- start is ignored unless busy==0 at the sampling edge. A start in the cycle done is high is accepted.

In-flight tracking and capture:
- inflight = reads issued whose data has not yet been captured; tracked with a C_RD_LATENCY-deep valid shift pipe.
- Data is written into the FIFO on the edge where the pipe tail is valid.
- Tail of pipe also carries a last flag, set for the read issued at address width-1.

Timing:
- start at edge T -> rd_en high in cycle T+1 -> first m_valid in cycle T+2+C_RD_LATENCY.
- With m_ready held high, throughput is 1 beat/cycle, no bubbles.

Output FIFO:
- m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
- Must be stable while m_valid & !m_ready.
- Simultaneous push and pop: count unchanged. Credit check uses the registered count, with no pop lookahead.
- The FIFO can never overflow; the implementation includes an assertion for this.

Arithmetic:
- rd_addr counter wraps never: reads stop at width-1.
- Internal counters are C_ADDR_WIDTH bits wide, except fifo_count, which is clog2(C_FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro SCALER_LINE_READER_SOF_EN.
- When defined:
  - Adds input sof_in (sampled with start).
  - Adds output m_user (1 bit), high on the first beat of a line started with sof_in=1, low on all other beats.
  - m_user is carried through the pipe and FIFO alongside the data.
- When undefined: no sof_in or m_user ports, and no extra storage.

Decomposition:
- Shared package scaler_pkg:
  - legal-range constants for C_RD_LATENCY;
  - the FIFO entry struct typedef {data, last[, user]};
  - the state enum (IDLE/READ/DRAIN).
- One natural sub-module: scaler_reader_fifo.
  - Synchronous FIFO with count output, same async reset.
  - Instantiated once for the output FIFO.

Test Plan:
- Full rate: width=8, L=1, m_ready=1. Expect beats at addresses 0..7, first m_valid 3 cycles after start, 8 consecutive beats, m_last on beat 7, done on that edge.
- Backpressure: width=16, L=2, m_ready toggles 1010… Expect all 16 pixels in order, no loss or duplication, rd_en throttled so fifo_count never exceeds 4.
- Stall then release: width=10, m_ready=0 for 20 cycles then 1. Expect rd_en to stop after 4 reads. m_data holds at pixel 0 while stalled, then 10 beats stream.
- Zero width: line_width=0 start. Expect no rd_en, no m_valid, done pulses next cycle, busy stays 0. Start while busy (width=5 running) is ignored, and only 5 beats are produced.
- Reset mid-line: width=12, assert resetn=0 after 6 beats. Expect all outputs at reset values immediately; a new start of width=3 then yields exactly pixels 0,1,2.
- SOF_EN build: two lines, sof_in=1 then 0. Expect m_user high only on the first beat of line 1.
